pattern_seq_gen: RTL and testbench

PATTERN_SEQ_GEN -- requirements
Module: pattern_seq_gen

---
 rtl/pattern_seq_gen.sv | 169 ++++++++++++++++
 tb/tb_pattern_seq_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_seq_gen.sv
// Serial pattern generator: shifts a programmable pattern out LSB-first, each bit held CLK_DIV clocks.
// Define PSG_DOUBLE_BUFFER_EN to allow loads during RUN via a shadow register applied at pass boundaries.
module pattern_seq_gen #(
  parameter int                CLK_DIV  = 12500000,
  parameter int                PAT_W    = 16,
  parameter logic [PAT_W-1:0]  PAT_INIT = 16'h00ED,
  parameter int                LEN_INIT = 10,
  localparam int               LEN_W    = $clog2(PAT_W + 1)
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iLOAD,
  input  logic [PAT_W-1:0] iPAT,
  input  logic [LEN_W-1:0] iLEN,
  input  logic             iSTART,
  input  logic             iSTOP,
  input  logic             iMODE,
  output logic             oSIG,
  output logic             oBUSY,
  output logic             oWRAP,
  output logic [LEN_W-1:0] oIDX
);

  localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               sig_q, sig_d;
  logic               wrap_q, wrap_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               mode_q, mode_d;
`ifdef PSG_DOUBLE_BUFFER_EN
  logic [PAT_W-1:0]   shd_pat_q, shd_pat_d;
  logic [LEN_W-1:0]   shd_len_q, shd_len_d;
  logic               pend_q, pend_d;
`endif

  logic [LEN_W-1:0]   ld_len;
  logic [PAT_W-1:0]   next_bits;
  logic               last_div;
  logic               last_bit;
  logic               pass_end;
  logic               go_idle;

  // Zero or oversize lengths mean "use the full pattern width".
  assign ld_len    = (iLEN == '0 || iLEN > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : iLEN;
  assign next_bits = pat_q >> (idx_q + 1'b1);
  assign last_div  = (div_q == DIV_MAX);
  assign last_bit  = (idx_q == len_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    sig_d    = sig_q;
    wrap_d   = 1'b0;
    pat_d    = pat_q;
    len_d    = len_q;
    mode_d   = mode_q;
    pass_end = 1'b0;
    go_idle  = 1'b0;
`ifdef PSG_DOUBLE_BUFFER_EN
    shd_pat_d = shd_pat_q;
    shd_len_d = shd_len_q;
    pend_d    = pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (iLOAD) begin
          pat_d = iPAT;
          len_d = ld_len;
        end
        if (iSTART && !iSTOP) begin
          state_d = RUN;
          mode_d  = iMODE;
          idx_d   = '0;
          div_d   = '0;
          sig_d   = pat_d[0];
        end
      end
      RUN: begin
`ifdef PSG_DOUBLE_BUFFER_EN
        if (iLOAD) begin
          shd_pat_d = iPAT;
          shd_len_d = ld_len;
          pend_d    = 1'b1;
        end
`endif
        if (iSTOP) begin
          go_idle = 1'b1;
        end else if (last_div) begin
          div_d = '0;
          if (last_bit) begin
            wrap_d   = 1'b1;
            pass_end = 1'b1;
            idx_d    = '0;
            go_idle  = mode_q;
          end else begin
            idx_d = idx_q + 1'b1;
            sig_d = next_bits[0];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

`ifdef PSG_DOUBLE_BUFFER_EN
    if ((pass_end || go_idle) && pend_d) begin
      pat_d  = shd_pat_d;
      len_d  = shd_len_d;
      pend_d = 1'b0;
    end
`endif

    if (go_idle) begin
      state_d = IDLE;
      sig_d   = 1'b0;
      idx_d   = '0;
      div_d   = '0;
    end else if (pass_end) begin
      sig_d = pat_d[0];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      sig_q   <= 1'b0;
      wrap_q  <= 1'b0;
      pat_q   <= PAT_INIT;
      len_q   <= LEN_W'(LEN_INIT);
      mode_q  <= 1'b0;
`ifdef PSG_DOUBLE_BUFFER_EN
      shd_pat_q <= PAT_INIT;
      shd_len_q <= LEN_W'(LEN_INIT);
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      wrap_q  <= wrap_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
`ifdef PSG_DOUBLE_BUFFER_EN
      shd_pat_q <= shd_pat_d;
      shd_len_q <= shd_len_d;
      pend_q    <= pend_d;
`endif
    end
  end

  assign oSIG  = sig_q;
  assign oBUSY = (state_q == RUN);
  assign oWRAP = wrap_q;
  assign oIDX  = idx_q;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Scoreboard bench for pattern_seq_gen with CLK_DIV=4, PAT_W=16.
// Each expected word is {busy, wrap, sig, idx[4:0]}, one per clock.
module tb_pattern_seq_gen;

  localparam int CLK_DIV = 4;
  localparam int PAT_W   = 16;
  localparam int LEN_W   = 5;
  localparam int W       = 8;

  logic             iCLK = 1'b0;
  logic             iRST_N;
  logic             iLOAD;
  logic [PAT_W-1:0] iPAT;
  logic [LEN_W-1:0] iLEN;
  logic             iSTART;
  logic             iSTOP;
  logic             iMODE;
  logic             oSIG;
  logic             oBUSY;
  logic             oWRAP;
  logic [LEN_W-1:0] oIDX;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  pattern_seq_gen #(.CLK_DIV(CLK_DIV), .PAT_W(PAT_W)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iLOAD(iLOAD), .iPAT(iPAT), .iLEN(iLEN),
    .iSTART(iSTART), .iSTOP(iSTOP), .iMODE(iMODE),
    .oSIG(oSIG), .oBUSY(oBUSY), .oWRAP(oWRAP), .oIDX(oIDX)
  );

  // clock / reset
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] obs();
    return {oBUSY, oWRAP, oSIG, oIDX};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (busy,wrap,sig,idx)", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge iCLK);
    #1;
    iLOAD  = 1'b0;
    iSTART = 1'b0;
    iSTOP  = 1'b0;
  endtask

  task automatic push_pass(input logic [PAT_W-1:0] pat, input int len, input bit wrap);
    for (int b = 0; b < len; b++)
      for (int c = 0; c < CLK_DIV; c++)
        exp_q.push_back({1'b1, wrap && b == 0 && c == 0, pat[b], 5'(b)});
  endtask

  task automatic push_idle(input int n, input bit wrap);
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'b0, wrap && i == 0, 1'b0, 5'd0});
  endtask

  task automatic run_cycles(input string tag, input int n, input bit start_noise);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_underflow"}, obs(), 'x);
      end else begin
        e = exp_q.pop_front();
        check(tag, obs(), e);
      end
      if (start_noise) iSTART = ($urandom_range(0, 3) == 0);
      step();
    end
  endtask

  task automatic start(input bit load, input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                       input bit mode);
    iLOAD  = load;
    iPAT   = pat;
    iLEN   = len;
    iMODE  = mode;
    iSTART = 1'b1;
    step();
  endtask

  task automatic stop_and_idle(input string tag);
    exp_q.delete();
    iSTOP = 1'b1;
    push_idle(2, 1'b0);
    step();
    run_cycles(tag, 2, 1'b0);
  endtask

  initial begin
    logic [PAT_W-1:0] rp;
    iRST_N = 1'b0; iLOAD = 0; iPAT = '0; iLEN = '0; iSTART = 0; iSTOP = 0; iMODE = 0;
    repeat (3) @(posedge iCLK);
    #1 iRST_N = 1'b1;

    push_idle(2, 1'b0);
    run_cycles("reset", 2, 1'b0);

    // default pattern, repeat mode, gap-free wrap
    start(1'b0, '0, '0, 1'b0);
    push_pass(16'h00ED, 10, 1'b0);
    push_pass(16'h00ED, 10, 1'b1);
    push_pass(16'h00ED, 1, 1'b1);
    run_cycles("default_rep", exp_q.size(), 1'b0);
    stop_and_idle("default_stop");

    // one-shot with load in the start cycle
    start(1'b1, 16'h0003, 5'd3, 1'b1);
    push_pass(16'h0003, 3, 1'b0);
    push_idle(2, 1'b1);
    run_cycles("oneshot", exp_q.size(), 1'b0);

    // stop at idx 5 together with start
    start(1'b1, 16'h00ED, 5'd10, 1'b0);
    push_pass(16'h00ED, 10, 1'b0);
    run_cycles("pre_stop", 21, 1'b0);
    exp_q.delete();
    iSTOP = 1'b1;
    iSTART = 1'b1;
    push_idle(3, 1'b0);
    step();
    run_cycles("stop_start", 3, 1'b0);

    // length 0 clamps to 16; start strobes during RUN ignored
    start(1'b1, 16'hFFFF, 5'd0, 1'b0);
    push_pass(16'hFFFF, 16, 1'b0);
    push_pass(16'hFFFF, 16, 1'b1);
    push_pass(16'hFFFF, 1, 1'b1);
    run_cycles("len0", exp_q.size(), 1'b1);
    stop_and_idle("len0_stop");

    // length 1 repeats bit 0
    rp = PAT_W'($urandom_range(0, 65535)) | 16'h0001;
    start(1'b1, rp, 5'd1, 1'b0);
    push_pass(rp, 1, 1'b0);
    push_pass(rp, 1, 1'b1);
    push_pass(rp, 1, 1'b1);
    run_cycles("len1", exp_q.size(), 1'b0);
    stop_and_idle("len1_stop");

    // oversize length clamps, random pattern, one-shot
    rp = PAT_W'($urandom_range(0, 65535));
    start(1'b1, rp, 5'd20, 1'b1);
    push_pass(rp, 16, 1'b0);
    push_idle(2, 1'b1);
    run_cycles("len_big", exp_q.size(), 1'b0);

    // asynchronous reset mid-bit, restart from PAT_INIT
    rp = PAT_W'($urandom_range(0, 65535));
    start(1'b1, rp, 5'd5, 1'b0);
    push_pass(rp, 5, 1'b0);
    run_cycles("pre_rst", 10, 1'b0);
    exp_q.delete();
    #2 iRST_N = 1'b0;
    #1 check("rst_async", obs(), '0);
    @(posedge iCLK);
    #1 iRST_N = 1'b1;
    push_idle(2, 1'b0);
    run_cycles("rst_idle", 2, 1'b0);
    start(1'b0, '0, '0, 1'b0);
    push_pass(16'h00ED, 10, 1'b0);
    push_pass(16'h00ED, 1, 1'b1);
    run_cycles("rst_restart", exp_q.size(), 1'b0);
    stop_and_idle("rst_stop");

    // load during RUN at idx 3
    start(1'b0, '0, '0, 1'b0);
    push_pass(16'h00ED, 10, 1'b0);
`ifdef PSG_DOUBLE_BUFFER_EN
    push_pass(16'h0001, 2, 1'b1);
`else
    push_pass(16'h00ED, 10, 1'b1);
`endif
    run_cycles("run_load_pre", 14, 1'b0);
    iLOAD = 1'b1;
    iPAT  = 16'h0001;
    iLEN  = 5'd2;
    run_cycles("run_load", exp_q.size(), 1'b0);
    stop_and_idle("final_stop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
